// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and load/store ports onto one single-ported, fixed-latency word memory.
// Build option: define MEM_ARB_RR_EN for round-robin arbitration instead of data-over-fetch priority.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   // fetch port
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ready,
   output logic              if_rvalid,
   output logic [31:0]       if_rdata,
   // load/store port
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [1:0]        d_size,
   input  logic              d_unsigned,
   input  logic [31:0]       d_wdata,
   output logic              d_ready,
   output logic              d_rvalid,
   output logic [31:0]       d_rdata,
   output logic              d_err,
   // memory port
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-3:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             grant_d;
   logic             grant_if;
   logic             accept;
   logic             acc_misaligned;
   logic             d_misaligned;
   logic             if_misaligned;
   logic             prefer_d;
   logic [3:0]       d_be;
   logic [31:0]      d_wlane;
   logic [CNT_W-1:0] cnt;

   // context of the accepted transaction, frozen at acceptance
   logic             txn_data;
   logic             txn_we;
   logic             txn_unsigned;
   logic [1:0]       txn_size;
   logic [1:0]       txn_off;

   // byte/half lane select plus sign or zero extension of a returned word
   function automatic logic [31:0] load_extract(input logic [31:0] w,
                                                input logic [1:0]  size,
                                                input logic [1:0]  off,
                                                input logic        uns);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = w[7:0];
      h = off[1] ? w[31:16] : w[15:0];
      r = w;
      case (off)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      case (size)
         SZ_BYTE: r = uns ? {24'd0, b} : {{24{b[7]}}, b};
         SZ_HALF: r = uns ? {16'd0, h} : {{16{h[15]}}, h};
         default: r = w;
      endcase
      return r;
   endfunction

   always_comb begin
      d_misaligned = 1'b1;
      case (d_size)
         SZ_BYTE: d_misaligned = 1'b0;
         SZ_HALF: d_misaligned = d_addr[0];
         SZ_WORD: d_misaligned = |d_addr[1:0];
         default: d_misaligned = 1'b1;
      endcase
   end

   assign if_misaligned = |if_addr[1:0];

   // store lane enables and lane replication of right-aligned store data
   always_comb begin
      d_be    = 4'b1111;
      d_wlane = d_wdata;
      case (d_size)
         SZ_BYTE: begin
            d_be    = 4'b0001 << d_addr[1:0];
            d_wlane = {4{d_wdata[7:0]}};
         end
         SZ_HALF: begin
            d_be    = d_addr[1] ? 4'b1100 : 4'b0011;
            d_wlane = {2{d_wdata[15:0]}};
         end
         default: ;
      endcase
   end

`ifdef MEM_ARB_RR_EN
   logic data_first;

   // the port not granted most recently wins a tie; reset favours data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_first <= 1'b1;
      end else if (accept) begin
         data_first <= grant_if;
      end
   end

   assign prefer_d = data_first;
`else
   assign prefer_d = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, RESP: begin
            if (accept) begin
               state_nxt = acc_misaligned ? RESP : ISSUE;
            end else begin
               state_nxt = IDLE;
            end
         end
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (cnt == '0) state_nxt = RESP;
         default: state_nxt = IDLE;
      endcase
   end

   // grants are only offered while no transaction is in flight
   always_comb begin
      grant_d  = 1'b0;
      grant_if = 1'b0;
      if (state == IDLE || state == RESP) begin
         if (d_req && (prefer_d || !if_req)) begin
            grant_d = 1'b1;
         end else if (if_req) begin
            grant_if = 1'b1;
         end
      end
      d_ready  = grant_d;
      if_ready = grant_if;
   end

   assign accept         = grant_d | grant_if;
   assign acc_misaligned = grant_d ? d_misaligned : if_misaligned;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_en       <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_be       <= '0;
         mem_wdata    <= '0;
         if_rvalid    <= 1'b0;
         if_rdata     <= '0;
         d_rvalid     <= 1'b0;
         d_rdata      <= '0;
         d_err        <= 1'b0;
         cnt          <= '0;
         txn_data     <= 1'b0;
         txn_we       <= 1'b0;
         txn_unsigned <= 1'b0;
         txn_size     <= '0;
         txn_off      <= '0;
      end else begin
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         if_rvalid <= 1'b0;
         d_rvalid  <= 1'b0;
         d_err     <= 1'b0;

         if (accept) begin
            txn_data     <= grant_d;
            txn_we       <= grant_d & d_we;
            txn_unsigned <= grant_d & d_unsigned;
            txn_size     <= grant_d ? d_size : SZ_WORD;
            txn_off      <= grant_d ? d_addr[1:0] : 2'b00;
            if (acc_misaligned) begin
               // rejected accesses answer next cycle and never touch memory
               if (grant_d) begin
                  d_rvalid <= 1'b1;
                  d_err    <= 1'b1;
                  d_rdata  <= '0;
               end else begin
                  if_rvalid <= 1'b1;
                  if_rdata  <= '0;
               end
            end else begin
               mem_en   <= 1'b1;
               mem_we   <= grant_d & d_we;
               mem_addr <= grant_d ? d_addr[ADDR_W-1:2] : if_addr[ADDR_W-1:2];
               mem_be   <= grant_d ? d_be : 4'b1111;
               if (grant_d && d_we) begin
                  mem_wdata <= d_wlane;
               end
            end
         end

         if (state == ISSUE) begin
            cnt <= CNT_W'(LATENCY - 1);
         end else if (state == WAIT && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
         end

         if (state == WAIT && cnt == '0) begin
            if (txn_data) begin
               d_rvalid <= 1'b1;
               d_rdata  <= txn_we ? 32'd0
                                  : load_extract(mem_rdata, txn_size, txn_off, txn_unsigned);
            end else begin
               if_rvalid <= 1'b1;
               if_rdata  <= mem_rdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a byte-level memory and access model.
module tb_mem_port_arbiter;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned LAT    = 1;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ready;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [1:0]  d_size;
   logic        d_unsigned;
   logic [31:0] d_wdata;
   logic        d_ready;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        d_err;
   logic        mem_en;
   logic        mem_we;
   logic [29:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   logic [31:0] mem     [256];
   logic [31:0] ref_mem [256];
   logic        pre_we = 1'b0;
   logic [7:0]  pre_idx;
   logic [31:0] pre_data;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   mem_port_arbiter #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_size(d_size),
      .d_unsigned(d_unsigned), .d_wdata(d_wdata), .d_ready(d_ready),
      .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // memory: old word returned one cycle after mem_en, noise otherwise
   always @(posedge clk) begin
      if (pre_we) mem[pre_idx] <= pre_data;
      if (mem_en) begin
         mem_rdata <= mem[mem_addr[7:0]];
         if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
               if (mem_be[i]) mem[mem_addr[7:0]][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
         end
      end else begin
         mem_rdata <= $urandom;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model_load(input logic [31:0] word, input int unsigned nb,
                                              input int unsigned off, input bit uns);
      logic [31:0] mask;
      logic [31:0] val;
      if (nb >= 4) return word;
      mask = (32'd1 << (8 * nb)) - 32'd1;
      val  = (word >> (8 * off)) & mask;
      if (!uns && val[8*nb-1]) val = val | ~mask;
      return val;
   endfunction

   task automatic preload(input logic [7:0] idx, input logic [31:0] data);
      @(negedge clk);
      pre_we   = 1'b1;
      pre_idx  = idx;
      pre_data = data;
      ref_mem[idx] = data;
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   task automatic run_txn(input bit is_d, input bit we_i, input logic [31:0] addr,
                          input logic [1:0] size_i, input bit uns, input logic [31:0] wdata,
                          output logic [31:0] rd_obs);
      bit          we;
      bit          mis;
      bit          ready;
      logic [1:0]  size;
      int unsigned nb, off, widx, waited;
      int unsigned en_cyc, rv_cyc, n_en, n_rv, n_other;
      logic [31:0] word, exp_rd, exp_wd, exp_be, mask;
      logic [31:0] en_addr, en_wd, rv_data;
      logic        en_we, rv_err;
      logic [3:0]  en_be;

      we   = is_d ? we_i : 1'b0;
      size = is_d ? size_i : 2'd2;
      nb   = 32'd1 << size;
      off  = 32'(addr[1:0]);
      widx = 32'(addr[9:2]);
      mis  = (size == 2'd3) || ((addr % nb) != 0);
      word = mem[widx];
      mask = (nb >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
      if (mis || we) exp_rd = 32'd0;
      else if (is_d) exp_rd = model_load(word, nb, off, uns);
      else           exp_rd = word;
      exp_wd = (nb >= 4) ? wdata : (wdata & mask) * ((nb == 1) ? 32'h0101_0101 : 32'h0001_0001);
      exp_be = ((32'd1 << nb) - 32'd1) << off;

      @(negedge clk);
      if (is_d) begin
         d_req = 1'b1; d_we = we; d_addr = addr; d_size = size; d_unsigned = uns; d_wdata = wdata;
      end else begin
         if_req = 1'b1; if_addr = addr;
      end
      #1;
      waited = 0;
      ready  = is_d ? d_ready : if_ready;
      while (!ready && waited < 20) begin
         @(negedge clk); #1;
         waited++;
         ready = is_d ? d_ready : if_ready;
      end
      check("accept", 32'(ready), 32'd1);

      @(posedge clk); #1;
      // later input changes must not affect the accepted transaction
      if (is_d) begin
         d_req = 1'b0; d_we = 1'($urandom); d_addr = $urandom; d_size = 2'($urandom);
         d_unsigned = 1'($urandom); d_wdata = $urandom;
      end else begin
         if_req = 1'b0; if_addr = $urandom;
      end

      n_en = 0; n_rv = 0; n_other = 0; en_cyc = 0; rv_cyc = 0;
      en_addr = '0; en_wd = '0; en_we = 1'b0; en_be = '0;
      rv_data = 32'hDEAD_BEEF; rv_err = 1'bx;
      for (int unsigned c = 1; c <= LAT + 6; c++) begin
         if (c > 1) begin @(posedge clk); #1; end
         if (mem_en) begin
            n_en++;
            if (n_en == 1) begin
               en_cyc = c; en_addr = 32'(mem_addr); en_we = mem_we; en_be = mem_be; en_wd = mem_wdata;
            end
         end
         if (is_d ? d_rvalid : if_rvalid) begin
            n_rv++;
            if (n_rv == 1) begin
               rv_cyc = c; rv_data = is_d ? d_rdata : if_rdata; rv_err = d_err;
            end
         end
         if (is_d ? if_rvalid : d_rvalid) n_other++;
      end

      check("rv_count", n_rv, 32'd1);
      check("other_port_rv", n_other, 32'd0);
      check("rdata", rv_data, exp_rd);
      if (mis) begin
         check("mis_no_mem_en", n_en, 32'd0);
         check("mis_rv_cycle", rv_cyc, 32'd1);
         if (is_d) check("mis_err", 32'(rv_err), 32'd1);
      end else begin
         check("en_count", n_en, 32'd1);
         check("en_cycle", en_cyc, 32'd1);
         check("mem_addr", en_addr, addr >> 2);
         check("mem_we", 32'(en_we), 32'(we));
         if (!is_d) check("fetch_be", 32'(en_be), 32'hF);
         if (we) begin
            check("store_be", 32'(en_be), exp_be);
            check("store_wdata", en_wd, exp_wd);
            for (int unsigned i = 0; i < nb; i++) ref_mem[widx][8*(off+i) +: 8] = wdata[8*i +: 8];
         end
         check("rv_cycle", rv_cyc, LAT + 2);
         if (is_d) check("d_err", 32'(rv_err), 32'd0);
      end
      check("mem_word", mem[widx], ref_mem[widx]);
      rd_obs = rv_data;
   endtask

   logic [31:0] rd;
   int unsigned n_rv_rst;
   int unsigned n_grant;
   int unsigned n_both;
   int unsigned guard;
   bit          grant_is_d [4];
   bit          rr_mode;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
`ifdef MEM_ARB_RR_EN
      rr_mode = 1'b1;
`else
      rr_mode = 1'b0;
`endif
      rst_n = 1'b0;
      if_req = 1'b0; if_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_size = '0; d_unsigned = 1'b0; d_wdata = '0;

      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         pre_we = 1'b1; pre_idx = 8'(i); pre_data = $urandom; ref_mem[i] = pre_data;
      end
      @(negedge clk);
      pre_we = 1'b0;

      check("reset_mem_en", 32'(mem_en), 32'd0);
      check("reset_mem_be", 32'(mem_be), 32'd0);
      check("reset_rvalids", 32'({if_rvalid, d_rvalid, d_err}), 32'd0);
      check("reset_ready", 32'({if_ready, d_ready}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // worked examples
      preload(8'h40, 32'h00A0_0093);
      run_txn(1'b0, 1'b0, 32'h100, 2'd2, 1'b0, 32'd0, rd);
      check("ex_fetch", rd, 32'h00A0_0093);
      preload(8'h40, 32'h80FF_0011);
      run_txn(1'b1, 1'b0, 32'h103, 2'd0, 1'b0, 32'd0, rd);
      check("ex_lb_signed", rd, 32'hFFFF_FF80);
      run_txn(1'b1, 1'b0, 32'h103, 2'd0, 1'b1, 32'd0, rd);
      check("ex_lb_unsigned", rd, 32'h0000_0080);
      run_txn(1'b1, 1'b0, 32'h102, 2'd1, 1'b0, 32'd0, rd);
      check("ex_lh_signed", rd, 32'hFFFF_80FF);
      run_txn(1'b1, 1'b1, 32'h201, 2'd0, 1'b0, 32'h0000_00AB, rd);
      check("ex_sb_rdata", rd, 32'd0);
      run_txn(1'b1, 1'b0, 32'h202, 2'd2, 1'b0, 32'd0, rd);
      run_txn(1'b1, 1'b0, 32'h200, 2'd3, 1'b0, 32'd0, rd);
      run_txn(1'b0, 1'b0, 32'h102, 2'd2, 1'b0, 32'd0, rd);

      for (int n = 0; n < 80; n++) begin
         run_txn(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 32'($urandom_range(0, 1023)),
                 ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                 1'($urandom_range(0, 1)), $urandom, rd);
      end

      // reset while waiting on memory: outputs clear at once, late data is dropped
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h104; d_size = 2'd2; d_unsigned = 1'b0;
      @(posedge clk); #1;
      d_req = 1'b0;
      check("rst_pre_mem_en", 32'(mem_en), 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("rst_mem_en", 32'(mem_en), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_be", 32'(mem_be), 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_rvalid", 32'({if_rvalid, d_rvalid}), 32'd0);
      check("rst_if_rdata", if_rdata, 32'd0);
      check("rst_d_rdata", d_rdata, 32'd0);
      check("rst_d_err", 32'(d_err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      n_rv_rst = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (d_rvalid || if_rvalid) n_rv_rst++;
      end
      check("rst_no_late_rv", n_rv_rst, 32'd0);

      // both ports held high across four acceptances
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h40;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; d_size = 2'd2; d_unsigned = 1'b0;
      n_grant = 0; n_both = 0; guard = 0;
      while (n_grant < 4 && guard < 60) begin
         #1;
         if (d_ready && if_ready) n_both++;
         if (d_ready) begin grant_is_d[n_grant] = 1'b1; n_grant++; end
         else if (if_ready) begin grant_is_d[n_grant] = 1'b0; n_grant++; end
         @(negedge clk);
         guard++;
      end
      if_req = 1'b0; d_req = 1'b0;
      check("arb_grants", n_grant, 32'd4);
      check("arb_both_ready", n_both, 32'd0);
      for (int i = 0; i < 4; i++) begin
         if (i < int'(n_grant))
            check("arb_order", 32'(grant_is_d[i]), rr_mode ? 32'((i % 2) == 0) : 32'd1);
      end
      repeat (8) @(negedge clk);

      run_txn(1'b0, 1'b0, 32'h3FC, 2'd2, 1'b0, 32'd0, rd);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
